// File: rtl/mp_add_pkg.sv
// rtl/mp_add_pkg.sv - shared types and constants for the multi-precision add sequencer
package mp_add_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla16_ci.sv
// rtl/cla16_ci.sv - 16-bit two-level carry-lookahead adder with exposed carry-in and group carry c4
module cla16_ci (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c0,
    output logic [15:0] sum,
    output logic        cout,
    output logic        c4,
    output logic        a_msb,
    output logic        b_msb,
    output logic        s_msb
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [3:0]  gc;

    assign g = a & b;
    assign p = a ^ b;

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_grp
            localparam int B = 4 * k;
            assign gg[k] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                         | (p[B+3] & p[B+2] & p[B+1] & g[B]);
            assign gp[k] = &p[B+3:B];

            // In-group carries are fully expanded from the group carry-in, not rippled.
            assign c[B]   = gc[k];
            assign c[B+1] = g[B] | (p[B] & gc[k]);
            assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[k]);
            assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                          | (p[B+2] & p[B+1] & p[B] & gc[k]);
        end
    endgenerate

    assign gc[0] = c0;
    assign gc[1] = gg[0] | (gp[0] & c0);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c0);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & c0);
    assign cout  = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & c0);

    assign c4    = gc[1];
    assign sum   = p ^ c;
    assign a_msb = a[15];
    assign b_msb = b[15];
    assign s_msb = sum[15];

endmodule

// File: rtl/mp_add_seq.sv
// rtl/mp_add_seq.sv - wide add/subtract sequenced one 16-bit slice per cycle, LS slice first
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SLICE_W*WORDS-1:0] in_a,
    input  logic [SLICE_W*WORDS-1:0] in_b,
    input  logic                     in_sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SLICE_W*WORDS-1:0] out_sum,
    output logic                     out_cout,
    output logic                     out_ovf
);

    localparam int N     = SLICE_W * WORDS;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t           state_q, state_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [N-1:0]     sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               slice_c4_unused;
    logic               slice_a_msb;
    logic               slice_b_msb;
    logic               slice_s_msb;

    // Operands shift right each RUN cycle, so the active slice is always the low word.
    cla16_ci u_cla (
        .a     (a_q[SLICE_W-1:0]),
        .b     (b_q[SLICE_W-1:0]),
        .c0    (carry_q),
        .sum   (slice_sum),
        .cout  (slice_cout),
        .c4    (slice_c4_unused),
        .a_msb (slice_a_msb),
        .b_msb (slice_b_msb),
        .s_msb (slice_s_msb)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_sub ? ~in_b : in_b;
                    carry_d = in_sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> SLICE_W;
                b_d     = b_q >> SLICE_W;
                // Result words enter at the top; after WORDS shifts word 0 sits at the bottom.
                sum_d   = {slice_sum, sum_q[N-1:SLICE_W]};
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = slice_cout;
                    ovf_d   = (slice_a_msb == slice_b_msb) && (slice_s_msb != slice_a_msb);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// tb/tb_mp_add_seq.sv - directed self-checking bench for mp_add_seq with WORDS=4
module tb_mp_add_seq;

    logic        clk;
    logic        nrst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_sum;
    logic        out_cout;
    logic        out_ovf;

    int checks;
    int failures;

    mp_add_seq #(.WORDS(4)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%016h expected=0x%016h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic sub, input logic [63:0] es, input logic ec,
                          input logic eo, input int hold);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, ":in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        tick();
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = ~b;
        in_sub   = ~sub;
        check({tag, ":busy"}, 64'(in_ready), 64'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, ":latency"}, 64'(n), 64'd4);
        check({tag, ":sum"}, out_sum, es);
        check({tag, ":cout"}, 64'(out_cout), 64'(ec));
        check({tag, ":ovf"}, 64'(out_ovf), 64'(eo));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            tick();
            check({tag, ":hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, ":hold_sum"}, out_sum, es);
            check({tag, ":hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ":released"}, 64'(out_valid), 64'd0);
        check({tag, ":in_ready_after"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        nrst      = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_sum", out_sum, 64'd0);
        nrst = 1'b1;
        tick();
        check("reset_in_ready", 64'(in_ready), 64'd1);

        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_out_ready_valid", 64'(out_valid), 64'd0);
        check("idle_out_ready_in_ready", 64'(in_ready), 64'd1);

        run_op("carry_slice", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0,
               64'h0000_0000_0001_0000, 1'b0, 1'b0, 0);
        run_op("wrap_all", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
               64'h0, 1'b1, 1'b0, 0);
        run_op("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1, 0);
        run_op("sub_borrow", 64'h5, 64'h7, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 0);
        run_op("sub_noborrow", 64'h7, 64'h5, 1'b1,
               64'h2, 1'b1, 1'b0, 0);
        run_op("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 0);
        run_op("sub_zero", 64'h0, 64'h0, 1'b1,
               64'h0, 1'b1, 1'b0, 0);
        run_op("mixed", 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0,
               64'h2345_6789_ABCD_F001, 1'b0, 1'b0, 0);
        run_op("alt_carry", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0,
               64'h0001_0000_0001_0000, 1'b0, 1'b0, 0);
        run_op("neg_ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
               64'h0, 1'b1, 1'b1, 0);
        run_op("backpressure", 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0,
               64'h0000_0000_0001_0000, 1'b0, 1'b0, 5);
        run_op("after_bp", 64'h0000_0000_0000_00FF, 64'h0000_0000_0000_0001, 1'b0,
               64'h0000_0000_0000_0100, 1'b0, 1'b0, 0);

        run_op("pre_rst", 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 0);
        in_valid = 1'b1;
        in_a     = 64'h1234_5678_9ABC_DEF0;
        in_b     = 64'h1111_1111_1111_1111;
        in_sub   = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        nrst = 1'b0;
        #1;
        check("rst_run_valid", 64'(out_valid), 64'd0);
        check("rst_run_sum", out_sum, 64'd0);
        check("rst_run_cout", 64'(out_cout), 64'd0);
        check("rst_run_ovf", 64'(out_ovf), 64'd0);
        tick();
        nrst = 1'b1;
        tick();
        check("rst_release_in_ready", 64'(in_ready), 64'd1);
        check("rst_release_valid", 64'(out_valid), 64'd0);
        run_op("post_rst", 64'h3, 64'h4, 1'b0, 64'h7, 1'b0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
